// File: rtl/l2_pkg.sv
// l2_pkg: shared constants, state encoding and data typedefs for the L2 burst adaptor
package l2_pkg;
  localparam int LINE_W   = 256;
  localparam int BURST_W  = 64;
  localparam int BEATS    = LINE_W / BURST_W;
  localparam int OFFSET_W = 5;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t;
  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] beat_t;
endpackage

// File: rtl/l2_burst_adaptor.sv
// l2_burst_adaptor: splits/assembles L2 cache lines into/from 4-beat memory bursts
module l2_burst_adaptor
  import l2_pkg::*;
#(
  parameter int LINE_W   = l2_pkg::LINE_W,
  parameter int BURST_W  = l2_pkg::BURST_W,
  parameter int OFFSET_W = l2_pkg::OFFSET_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cacheline_read,
  input  logic               cacheline_write,
  input  logic [31:0]        address_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               cacheline_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [31:0]        pmem_address,
  output logic [BURST_W-1:0] pmem_wdata,
  input  logic [BURST_W-1:0] pmem_rdata,
  input  logic               pmem_resp
);
  localparam int NB = LINE_W / BURST_W;
  localparam int BW = $clog2(NB);
  adaptor_state_t r_state, w_next;
  logic [BW-1:0]     r_beat;
  logic [LINE_W-1:0] r_buf;
  logic [31:0]       r_addr;
  logic              w_busy, w_last, w_start;
  assign w_busy  = (r_state == READ) || (r_state == WRITE);
  assign w_last  = w_busy && pmem_resp && (r_beat == BW'(NB - 1));
  assign w_start = (r_state == IDLE) && (cacheline_write || cacheline_read);
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (cacheline_write ? WRITE : cacheline_read ? READ : IDLE) :
             w_busy ? (w_last ? DONE : r_state) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_addr <= {address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
        r_beat <= '0;
        if (cacheline_write) r_buf <= line_i;
      end
      if (r_state == READ && pmem_resp) r_buf[r_beat*BURST_W +: BURST_W] <= pmem_rdata;
      if (w_busy && pmem_resp) r_beat <= r_beat + 1'b1;
    end
  end
  assign line_o         = r_buf;
  assign cacheline_resp = (r_state == DONE);
  assign pmem_read      = (r_state == READ);
  assign pmem_write     = (r_state == WRITE);
  assign pmem_address   = r_addr;
  assign pmem_wdata     = pmem_write ? r_buf[r_beat*BURST_W +: BURST_W] : '0;
endmodule

// File: tb/tb_l2_burst_adaptor.sv
// tb_l2_burst_adaptor: directed self-checking bench with a line scoreboard
module tb_l2_burst_adaptor;
  logic         clk = 0;
  logic         rst = 1;
  logic         cacheline_read = 0, cacheline_write = 0;
  logic [31:0]  address_i = '0;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic         cacheline_resp, pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata = '0;
  logic         pmem_resp = 0;
  int           errors = 0, checks = 0;
  logic [255:0] exp_q[$];

  l2_burst_adaptor dut (
    .clk(clk), .rst(rst), .cacheline_read(cacheline_read), .cacheline_write(cacheline_write),
    .address_i(address_i), .line_i(line_i), .line_o(line_o), .cacheline_resp(cacheline_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cacheline_resp) begin
      if (exp_q.size() == 0) chk("spurious_resp", cacheline_resp, 0);
      else chk("line_o_at_resp", line_o, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [63:0]  rb[4];
    logic [255:0] rline, wline, sline, bline, w2line;
    rb[0] = {8{8'hA0}}; rb[1] = {8{8'hB1}}; rb[2] = {8{8'hC2}}; rb[3] = {8{8'hD3}};
    rline = {rb[3], rb[2], rb[1], rb[0]};
    wline = 256'h0123456789abcdef_1122334455667788_99aabbccddeeff00_fedcba9876543210;
    sline = 256'h5555aaaa_12345678_9abcdef0_0badf00d_deadbeef_cafef00d_76543210_fedcba98;
    bline = 256'h1111111111111111_2222222222222222_3333333333333333_4444444444444444;
    w2line = ~wline;

    tick(); tick();
    rst = 0;
    tick();
    chk("rst_line_o", line_o, 0);
    chk("rst_resp", cacheline_resp, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);

    // read without stalls
    cacheline_read = 1; address_i = 32'h0000_1234; exp_q.push_back(rline);
    tick();
    chk("rd_pmem_read", pmem_read, 1);
    chk("rd_address", pmem_address, 32'h0000_1220);
    chk("rd_no_resp_early", cacheline_resp, 0);
    for (int i = 0; i < 4; i++) begin
      pmem_resp = 1; pmem_rdata = rb[i];
      if (i == 2) address_i = 32'hFFFF_FFFF;
      tick();
      chk("rd_resp_timing", cacheline_resp, (i == 3) ? 1 : 0);
      chk("rd_pmem_read_window", pmem_read, (i < 3) ? 1 : 0);
      chk("rd_address_hold", pmem_address, 32'h0000_1220);
    end
    pmem_resp = 0; cacheline_read = 0;
    tick();
    chk("rd_resp_one_cycle", cacheline_resp, 0);
    chk("rd_line_hold", line_o, rline);

    // write with stalls on every other cycle
    cacheline_write = 1; address_i = 32'h8000_00FF; line_i = wline; exp_q.push_back(wline);
    tick();
    line_i = ~wline;
    chk("wr_address", pmem_address, 32'h8000_00E0);
    for (int c = 0; c < 8; c++) begin
      chk("wr_pmem_write", pmem_write, 1);
      chk("wr_pmem_read_low", pmem_read, 0);
      chk("wr_wdata", pmem_wdata, wline[(c/2)*64 +: 64]);
      pmem_resp = c[0];
      tick();
    end
    chk("wr_resp_after_4th", cacheline_resp, 1);
    pmem_resp = 0; cacheline_write = 0;
    tick();
    chk("wr_resp_one_cycle", cacheline_resp, 0);

    // simultaneous read and write: write wins
    cacheline_read = 1; cacheline_write = 1; address_i = 32'h0000_4000; line_i = sline; exp_q.push_back(sline);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("both_pmem_write", pmem_write, 1);
      chk("both_pmem_read_low", pmem_read, 0);
      pmem_resp = 1; pmem_rdata = 64'hBAD0BAD0BAD0BAD0;
      tick();
    end
    chk("both_resp", cacheline_resp, 1);
    chk("both_read_low_done", pmem_read, 0);
    pmem_resp = 0; cacheline_read = 0; cacheline_write = 0;
    tick();

    // reset after two read beats
    cacheline_read = 1; address_i = 32'h0000_5000;
    tick();
    for (int i = 0; i < 2; i++) begin
      pmem_resp = 1; pmem_rdata = rb[i];
      tick();
    end
    rst = 1;
    tick();
    rst = 0; cacheline_read = 0; pmem_resp = 0;
    chk("rstmid_pmem_read", pmem_read, 0);
    chk("rstmid_line_o", line_o, 0);
    chk("rstmid_resp", cacheline_resp, 0);
    pmem_resp = 1; pmem_rdata = rb[3];
    tick();
    pmem_resp = 0;
    chk("stray_pmem_read", pmem_read, 0);
    chk("stray_pmem_write", pmem_write, 0);
    chk("stray_resp", cacheline_resp, 0);
    chk("stray_line_o", line_o, 0);
    tick();
    chk("stray_resp2", cacheline_resp, 0);

    // back-to-back read then write
    cacheline_read = 1; address_i = 32'h0000_2047; exp_q.push_back(bline);
    tick();
    for (int i = 0; i < 4; i++) begin
      pmem_resp = 1; pmem_rdata = bline[i*64 +: 64];
      tick();
    end
    pmem_resp = 0;
    chk("b2b_rd_resp", cacheline_resp, 1);
    cacheline_read = 0; cacheline_write = 1; address_i = 32'h3000_0010; line_i = w2line;
    exp_q.push_back(w2line);
    tick();
    chk("b2b_idle_write_low", pmem_write, 0);
    chk("b2b_idle_resp_low", cacheline_resp, 0);
    tick();
    chk("b2b_write_start", pmem_write, 1);
    chk("b2b_new_address", pmem_address, 32'h3000_0000);
    chk("b2b_beat0", pmem_wdata, w2line[63:0]);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_wdata", pmem_wdata, w2line[i*64 +: 64]);
      pmem_resp = 1;
      tick();
    end
    chk("b2b_wr_resp", cacheline_resp, 1);
    pmem_resp = 0; cacheline_write = 0;
    tick();

    // idle noise on pmem_resp
    for (int i = 0; i < 4; i++) begin
      pmem_resp = ~pmem_resp;
      tick();
      chk("idle_resp", cacheline_resp, 0);
      chk("idle_pmem_read", pmem_read, 0);
      chk("idle_pmem_write", pmem_write, 0);
      chk("idle_line_o", line_o, w2line);
    end
    pmem_resp = 0;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
